// File: rtl/eth_rx_pkg.sv
// Shared constants, FSM encodings and helpers for the RMII receive frame buffer.
package eth_rx_pkg;

  localparam int          FCS_LEN = 4;
  localparam int          DESC_W  = 11;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_RECV = 2'd1,
    W_DROP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_FETCH  = 2'd1,
    R_STREAM = 2'd2
  } rd_state_t;

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_rx_desc_fifo.sv
// Frame-length descriptor FIFO; Full/Empty are registered from the next occupancy.
module eth_rx_desc_fifo
  import eth_rx_pkg::*;
#(
  parameter int pDEPTH = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Push,
  input  logic [DESC_W-1:0] PushData,
  input  logic              Pop,
  output logic [DESC_W-1:0] PopData,
  output logic              Full,
  output logic              Empty
);

  localparam int IW = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;

  logic [DESC_W-1:0] mem [pDEPTH];
  logic [IW-1:0]     wIdx, rIdx;
  logic [IW:0]       cnt, cntNxt;
  logic              doPush, doPop;

  assign doPush  = Push && !Full;
  assign doPop   = Pop && !Empty;
  assign PopData = mem[rIdx];

  always_comb begin
    cntNxt = cnt;
    if (doPush && !doPop) cntNxt = cnt + 1'b1;
    if (doPop && !doPush) cntNxt = cnt - 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wIdx  <= '0;
      rIdx  <= '0;
      cnt   <= '0;
      Full  <= 1'b0;
      Empty <= 1'b1;
    end else begin
      if (doPush) wIdx <= wIdx + 1'b1;
      if (doPop)  rIdx <= rIdx + 1'b1;
      cnt   <= cntNxt;
      Full  <= (cntNxt == (IW+1)'(pDEPTH));
      Empty <= (cntNxt == '0);
    end
  end

  always_ff @(posedge Clk) begin
    if (doPush) mem[wIdx] <= PushData;
  end

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// RMII receive frame buffer: circular byte RAM, commit/rewind on frame end, valid/ready drain.
// Optional counters Good_Cnt / Crc_Err_Cnt are built when ETH_RX_STATS_EN is defined.
module eth_rx_frame_ctrl
  import eth_rx_pkg::*;
#(
  parameter int pADDR_W     = 11,
  parameter int pDESC_DEPTH = 4,
  parameter int pMIN_LEN    = 64,
  parameter int pMAX_LEN    = 1518
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Byte_Rdy,
  input  logic [7:0]  Byte,
  input  logic        Frame_End,
  input  logic        Crc_Valid,
  input  logic        Rd_Ready,
  output logic        Rd_Valid,
  output logic [7:0]  Rd_Data,
  output logic        Rd_Last,
  output logic        Frm_Avail,
  output logic [15:0] Drop_Cnt
`ifdef ETH_RX_STATS_EN
  ,
  output logic [15:0] Good_Cnt,
  output logic [15:0] Crc_Err_Cnt
`endif
);

  localparam int                PW    = pADDR_W + 1;
  localparam int                DEPTH = 1 << pADDR_W;
  localparam logic [PW-1:0]     CAP   = PW'(1) << pADDR_W;
  localparam logic [PW-1:0]     FCS_P = PW'(FCS_LEN);
  localparam logic [DESC_W-1:0] FCS_D = DESC_W'(FCS_LEN);
  localparam logic [DESC_W-1:0] MIN_L = DESC_W'(pMIN_LEN);
  localparam logic [DESC_W-1:0] MAX_L = DESC_W'(pMAX_LEN);

  wr_state_t wState, wNext;
  rd_state_t rState, rNext;

  logic [PW-1:0]      wrPtr, commitPtr, rdPtr, used, wrPtrInc;
  logic [DESC_W-1:0]  len, lenNxt, rem, descIn, descOut;
  logic               bufFull, byteAcc, byteOvf, frmActive, dropping;
  logic               accept, rewind, dropInc;
  logic               descPush, descPop, descFull, descEmpty;
  logic               hs;
  logic [pADDR_W-1:0] rdLo, rdAddr;
  logic [7:0]         mem [DEPTH];
  logic [7:0]         ramQ;

  assign used     = wrPtr - rdPtr;
  assign bufFull  = (used == CAP);
  assign wrPtrInc = wrPtr + PW'(byteAcc);
  assign rdLo     = rdPtr[pADDR_W-1:0];
  assign descPush = accept;
  assign descIn   = lenNxt - FCS_D;

  // ---------------- write FSM ----------------
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) wState <= W_IDLE;
    else      wState <= wNext;
  end

  always_comb begin
    wNext = wState;
    unique case (wState)
      W_IDLE: begin
        if (Frame_End)    wNext = W_IDLE;
        else if (byteOvf) wNext = W_DROP;
        else if (byteAcc) wNext = W_RECV;
      end
      W_RECV: begin
        if (Frame_End)    wNext = W_IDLE;
        else if (byteOvf) wNext = W_DROP;
      end
      W_DROP: if (Frame_End) wNext = W_IDLE;
      default: wNext = W_IDLE;
    endcase
  end

  // A byte arriving with Frame_End is folded into len before the verdict.
  always_comb begin
    byteAcc = 1'b0;
    byteOvf = 1'b0;
    if (Byte_Rdy && wState != W_DROP) begin
      if (bufFull || (wState == W_RECV && len == MAX_L)) byteOvf = 1'b1;
      else                                               byteAcc = 1'b1;
    end
    lenNxt = len;
    if (byteAcc) lenNxt = (wState == W_IDLE) ? DESC_W'(1) : len + 1'b1;
    frmActive = (wState != W_IDLE) || byteAcc || byteOvf;
    dropping  = (wState == W_DROP) || byteOvf;
    accept    = Frame_End && frmActive && !dropping && Crc_Valid &&
                (lenNxt >= MIN_L) && !descFull;
    rewind    = Frame_End && frmActive && !accept;
    dropInc   = Frame_End && !accept;
  end

  // Commit point sits on the FCS so the next frame overwrites it; the reader never sees it.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wrPtr     <= '0;
      commitPtr <= '0;
      len       <= '0;
      Drop_Cnt  <= '0;
    end else begin
      len <= lenNxt;
      if (rewind) begin
        wrPtr <= commitPtr;
      end else if (accept) begin
        wrPtr     <= wrPtrInc - FCS_P;
        commitPtr <= wrPtrInc - FCS_P;
      end else begin
        wrPtr <= wrPtrInc;
      end
      if (dropInc) Drop_Cnt <= satInc(Drop_Cnt);
    end
  end

  always_ff @(posedge Clk) begin
    if (byteAcc) mem[wrPtr[pADDR_W-1:0]] <= Byte;
    ramQ <= mem[rdAddr];
  end

  eth_rx_desc_fifo #(.pDEPTH(pDESC_DEPTH)) uDescFifo (
    .Clk      (Clk),
    .Rst      (Rst),
    .Push     (descPush),
    .PushData (descIn),
    .Pop      (descPop),
    .PopData  (descOut),
    .Full     (descFull),
    .Empty    (descEmpty)
  );

  // ---------------- read FSM ----------------
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) rState <= R_IDLE;
    else      rState <= rNext;
  end

  always_comb begin
    rNext = rState;
    unique case (rState)
      R_IDLE:   if (descPop) rNext = R_FETCH;
      R_FETCH:  rNext = R_STREAM;
      R_STREAM: if (hs && Rd_Last) rNext = R_IDLE;
      default:  rNext = R_IDLE;
    endcase
  end

  // ramQ always holds the byte after the one on Rd_Data, so a handshake can reload it at once.
  always_comb begin
    descPop  = 1'b0;
    hs       = 1'b0;
    rdAddr   = rdLo;
    Rd_Valid = (rState == R_STREAM);
    unique case (rState)
      R_IDLE:   descPop = Frm_Avail && !descEmpty;
      R_FETCH:  rdAddr  = rdLo + pADDR_W'(1);
      R_STREAM: begin
        hs     = Rd_Ready;
        rdAddr = Rd_Ready ? rdLo + pADDR_W'(2) : rdLo + pADDR_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rdPtr     <= '0;
      rem       <= '0;
      Rd_Data   <= '0;
      Rd_Last   <= 1'b0;
      Frm_Avail <= 1'b0;
    end else begin
      Frm_Avail <= !descEmpty;
      if (descPop) rem <= descOut;
      if (rState == R_FETCH) begin
        Rd_Data <= ramQ;
        Rd_Last <= (rem == DESC_W'(1));
      end
      if (hs) begin
        rdPtr <= rdPtr + PW'(1);
        if (Rd_Last) begin
          Rd_Last <= 1'b0;
        end else begin
          rem     <= rem - 1'b1;
          Rd_Data <= ramQ;
          Rd_Last <= (rem == DESC_W'(2));
        end
      end
    end
  end

`ifdef ETH_RX_STATS_EN
  logic crcErr;
  assign crcErr = Frame_End && frmActive && !dropping && !Crc_Valid;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Good_Cnt    <= '0;
      Crc_Err_Cnt <= '0;
    end else begin
      if (accept) Good_Cnt    <= satInc(Good_Cnt);
      if (crcErr) Crc_Err_Cnt <= satInc(Crc_Err_Cnt);
    end
  end
`endif

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Bench for eth_rx_frame_ctrl: frame table, latency, overflow, FIFO-full and reset sequences.
module tb_eth_rx_frame_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Byte_Rdy = 1'b0;
  logic [7:0]  Byte = '0;
  logic        Frame_End = 1'b0;
  logic        Crc_Valid = 1'b0;
  logic        Rd_Ready = 1'b0;
  logic        Rd_Valid;
  logic [7:0]  Rd_Data;
  logic        Rd_Last;
  logic        Frm_Avail;
  logic [15:0] Drop_Cnt;

  eth_rx_frame_ctrl dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Byte_Rdy  (Byte_Rdy),
    .Byte      (Byte),
    .Frame_End (Frame_End),
    .Crc_Valid (Crc_Valid),
    .Rd_Ready  (Rd_Ready),
    .Rd_Valid  (Rd_Valid),
    .Rd_Data   (Rd_Data),
    .Rd_Last   (Rd_Last),
    .Frm_Avail (Frm_Avail),
    .Drop_Cnt  (Drop_Cnt)
  );

  always #10 Clk = ~Clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  typedef struct {
    int         len;
    bit         crc;
    bit         same;
    logic [7:0] seed;
    int         expBytes;
    int         expDropInc;
  } vec_t;

  exp_t sb[$];
  int   nChecks = 0;
  int   nErrors = 0;
  int   gotBytes = 0;
  int   expDrop = 0;
  int   rdyMode = 1;   // 0: Rd_Ready low, 1: high, 2: random

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge Clk); #2;
    case (rdyMode)
      0:       Rd_Ready = 1'b0;
      1:       Rd_Ready = 1'b1;
      default: Rd_Ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard: every accepted handshake must match the head of the expected stream.
  initial forever begin
    @(negedge Clk);
    if (Rst && Rd_Valid && Rd_Ready) begin
      nChecks++;
      gotBytes++;
      if (sb.size() == 0) begin
        nErrors++;
        $display("FAIL rd_byte: got %02h/%0b expected nothing", Rd_Data, Rd_Last);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (Rd_Data !== e.d || Rd_Last !== e.l) begin
          nErrors++;
          $display("FAIL rd_byte: got %02h/%0b expected %02h/%0b", Rd_Data, Rd_Last, e.d, e.l);
        end
      end
    end
  end

  initial begin
    #1900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic sendFrame(input int len, input bit crc, input bit good,
                           input logic [7:0] seed, input bit same);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      @(posedge Clk); #1;
      b = seed + 8'(i);
      Byte_Rdy  = 1'b1;
      Byte      = b;
      Crc_Valid = crc;
      Frame_End = same && (i == len - 1);
      if (good && i < len - 4) sb.push_back('{d: b, l: (i == len - 5)});
    end
    if (!same || len == 0) begin
      @(posedge Clk); #1;
      Byte_Rdy  = 1'b0;
      Frame_End = 1'b1;
      Crc_Valid = crc;
    end
    @(posedge Clk); #1;
    Byte_Rdy  = 1'b0;
    Frame_End = 1'b0;
    Crc_Valid = 1'b0;
  endtask

  task automatic waitDrain(input string nm, input int maxCyc);
    int n;
    n = 0;
    repeat (6) @(posedge Clk);
    #1;
    while ((sb.size() != 0 || Rd_Valid || Frm_Avail) && n < maxCyc) begin
      @(posedge Clk); #1;
      n++;
    end
    chk({nm, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic applyReset();
    @(posedge Clk); #5;
    Rst = 1'b0;
    #1;
    chk("reset_outputs", {13'd0, Rd_Valid, Rd_Data, Rd_Last, Frm_Avail, Drop_Cnt}, 32'd0);
    Byte_Rdy  = 1'b0;
    Frame_End = 1'b0;
    Crc_Valid = 1'b0;
    sb.delete();
    expDrop = 0;
    @(negedge Clk);
    Rst = 1'b1;
    gotBytes = 0;
  endtask

  vec_t tbl[8];

  initial begin
    // len, crc, same-cycle end, seed, delivered bytes, drop increment
    tbl[0] = '{64,   1'b0, 1'b0, 8'h11, 0,    1};
    tbl[1] = '{100,  1'b1, 1'b0, 8'h22, 96,   0};
    tbl[2] = '{63,   1'b1, 1'b0, 8'h33, 0,    1};
    tbl[3] = '{64,   1'b1, 1'b1, 8'h44, 60,   0};
    tbl[4] = '{1518, 1'b1, 1'b0, 8'h55, 1514, 0};
    tbl[5] = '{1519, 1'b1, 1'b0, 8'h66, 0,    1};
    tbl[6] = '{0,    1'b1, 1'b0, 8'h00, 0,    1};
    tbl[7] = '{1,    1'b1, 1'b1, 8'h77, 0,    1};

    repeat (3) @(posedge Clk);
    #1;
    chk("por_outputs", {13'd0, Rd_Valid, Rd_Data, Rd_Last, Frm_Avail, Drop_Cnt}, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;

    // First frame: Rd_Valid rises on the third edge after Frame_End is sampled.
    rdyMode = 1;
    sendFrame(64, 1'b1, 1'b1, 8'hA0, 1'b0);
    chk("lat_e0_valid", 32'(Rd_Valid), 32'd0);
    chk("lat_e0_avail", 32'(Frm_Avail), 32'd0);
    @(posedge Clk); #1;
    chk("lat_e1_avail", 32'(Frm_Avail), 32'd1);
    chk("lat_e1_valid", 32'(Rd_Valid), 32'd0);
    @(posedge Clk); #1;
    chk("lat_e2_valid", 32'(Rd_Valid), 32'd0);
    @(posedge Clk); #1;
    chk("lat_e3_valid", 32'(Rd_Valid), 32'd1);
    chk("lat_e3_avail", 32'(Frm_Avail), 32'd0);
    waitDrain("lat", 200);
    chk("lat_bytes", 32'(gotBytes), 32'd60);
    chk("lat_drop", 32'(Drop_Cnt), 32'd0);

    for (int k = 0; k < 8; k++) begin
      gotBytes = 0;
      sendFrame(tbl[k].len, tbl[k].crc, tbl[k].expBytes != 0, tbl[k].seed, tbl[k].same);
      expDrop += tbl[k].expDropInc;
      waitDrain($sformatf("vec%0d", k), 4000);
      chk($sformatf("vec%0d_drop", k), 32'(Drop_Cnt), 32'(expDrop));
      chk($sformatf("vec%0d_bytes", k), 32'(gotBytes), 32'(tbl[k].expBytes));
    end

    // Stalled reader: a 1500-byte frame leaves 552 free bytes, so a 600-byte frame overflows.
    rdyMode = 0;
    gotBytes = 0;
    sendFrame(1500, 1'b1, 1'b1, 8'h05, 1'b0);
    sendFrame(600, 1'b1, 1'b0, 8'h90, 1'b0);
    expDrop++;
    chk("ovf_drop", 32'(Drop_Cnt), 32'(expDrop));
    rdyMode = 1;
    waitDrain("ovf", 3000);
    chk("ovf_bytes", 32'(gotBytes), 32'd1496);
    gotBytes = 0;
    sendFrame(100, 1'b1, 1'b1, 8'hC3, 1'b0);
    waitDrain("ovf_after", 400);
    chk("ovf_after_bytes", 32'(gotBytes), 32'd96);

    // The reader pops frame 1 into its byte counter, frames 2-5 fill the FIFO, frame 6 is dropped.
    rdyMode = 0;
    gotBytes = 0;
    for (int f = 0; f < 6; f++)
      sendFrame(64, 1'b1, f < 5, 8'(8'h10 + 8'(f * 37)), 1'b0);
    expDrop++;
    chk("fifo_drop", 32'(Drop_Cnt), 32'(expDrop));
    chk("fifo_avail", 32'(Frm_Avail), 32'd1);
    rdyMode = 2;
    waitDrain("fifo", 5000);
    chk("fifo_bytes", 32'(gotBytes), 32'd300);

    // Reset in the middle of a frame with data already buffered and presented.
    rdyMode = 0;
    sendFrame(64, 1'b1, 1'b1, 8'h3C, 1'b0);
    sendFrame(64, 1'b1, 1'b1, 8'h4D, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(posedge Clk); #1;
      Byte_Rdy = 1'b1;
      Byte     = 8'(i);
    end
    chk("pre_rst_valid", 32'(Rd_Valid), 32'd1);
    applyReset();
    rdyMode = 1;
    sendFrame(80, 1'b1, 1'b1, 8'hE1, 1'b0);
    waitDrain("rst_frame", 400);
    chk("rst_frame_bytes", 32'(gotBytes), 32'd76);
    chk("rst_frame_drop", 32'(Drop_Cnt), 32'd0);

    // Reset in the middle of streaming a frame out.
    sendFrame(200, 1'b1, 1'b1, 8'h7E, 1'b0);
    repeat (20) @(posedge Clk);
    #1;
    chk("mid_read_valid", 32'(Rd_Valid), 32'd1);
    applyReset();
    sendFrame(70, 1'b1, 1'b1, 8'hB2, 1'b0);
    waitDrain("rst_read", 400);
    chk("rst_read_bytes", 32'(gotBytes), 32'd66);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
